// File: rtl/regbank_wb.sv
// regbank_wb: 6809 writeback pipeline and programmer-visible register bank.
// Optional 6309 registers (W/E/F/V) enabled by defining REGBANK_6309_EN.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   wb_valid_in/reg/data           ALU result write request, committed WB_LAT cycles later
//   wb_ccr_we_in, wb_ccr_in        optional CC update carried with the write
//   exg_valid_in, exg_r0/r1_in     single-cycle register exchange
//   pc_inc_in                      PC increment
//   rd_a/b_sel_in, rd_a/b_out      combinational operand read ports
//   cc_out, pc_out                 current CC and PC
//   hazard_out, busy_out           read-after-write alias flag, pipeline occupancy
module regbank_wb #(
    parameter int WB_LAT = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wb_valid_in,
    input  logic [3:0]  wb_reg_in,
    input  logic [15:0] wb_data_in,
    input  logic        wb_ccr_we_in,
    input  logic [7:0]  wb_ccr_in,
    input  logic        exg_valid_in,
    input  logic [3:0]  exg_r0_in,
    input  logic [3:0]  exg_r1_in,
    input  logic        pc_inc_in,
    input  logic [3:0]  rd_a_sel_in,
    input  logic [3:0]  rd_b_sel_in,
    output logic [15:0] rd_a_out,
    output logic [15:0] rd_b_out,
    output logic [7:0]  cc_out,
    output logic [15:0] pc_out,
    output logic        hazard_out,
    output logic        busy_out
);
    localparam int L = WB_LAT - 1;

    logic        pv_q   [WB_LAT];
    logic [3:0]  pr_q   [WB_LAT];
    logic [15:0] pd_q   [WB_LAT];
    logic        pwe_q  [WB_LAT];
    logic [7:0]  pcc_q  [WB_LAT];

    logic [7:0]  a_q, a_d, b_q, b_d, dp_q, dp_d, cc_q, cc_d;
    logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d, pc_q, pc_d;
`ifdef REGBANK_6309_EN
    logic [7:0]  e_q, e_d, f_q, f_d;
    logic [15:0] v_q, v_d;
`endif

    logic        w_en  [3];
    logic [3:0]  w_reg [3];
    logic [15:0] w_dat [3];

    function automatic logic [15:0] rd(input logic [3:0] s);
        case (s)
            4'h0: rd = {a_q, b_q};
            4'h1: rd = x_q;
            4'h2: rd = y_q;
            4'h3: rd = u_q;
            4'h4: rd = s_q;
            4'h5: rd = pc_q;
            4'h8: rd = {8'h00, a_q};
            4'h9: rd = {8'h00, b_q};
            4'hA: rd = {8'h00, cc_q};
            4'hB: rd = {8'h00, dp_q};
`ifdef REGBANK_6309_EN
            4'h6: rd = {e_q, f_q};
            4'h7: rd = v_q;
            4'hE: rd = {8'h00, e_q};
            4'hF: rd = {8'h00, f_q};
`endif
            default: rd = 16'hFFFF;
        endcase
    endfunction

    // Two codes alias when equal or when one is a 16-bit pair containing the other.
    function automatic logic ovl(input logic [3:0] p, input logic [3:0] q);
        ovl = (p == q)
            || (p == 4'h0 && (q == 4'h8 || q == 4'h9))
            || (q == 4'h0 && (p == 4'h8 || p == 4'h9))
`ifdef REGBANK_6309_EN
            || (p == 4'h6 && (q == 4'hE || q == 4'hF))
            || (q == 4'h6 && (p == 4'hE || p == 4'hF))
`endif
            ;
    endfunction

    assign rd_a_out = rd(rd_a_sel_in);
    assign rd_b_out = rd(rd_b_sel_in);
    assign cc_out   = cc_q;
    assign pc_out   = pc_q;

    // Write slots in increasing priority: the pipeline commit is applied last so it wins over EXG.
    assign w_en[0]  = exg_valid_in;
    assign w_reg[0] = exg_r0_in;
    assign w_dat[0] = rd(exg_r1_in);
    assign w_en[1]  = exg_valid_in;
    assign w_reg[1] = exg_r1_in;
    assign w_dat[1] = rd(exg_r0_in);
    assign w_en[2]  = pv_q[L];
    assign w_reg[2] = pr_q[L];
    assign w_dat[2] = pd_q[L];

    always_comb begin
        hazard_out = wb_valid_in && (ovl(rd_a_sel_in, wb_reg_in) || ovl(rd_b_sel_in, wb_reg_in));
        busy_out   = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            hazard_out = hazard_out || (pv_q[i] && (ovl(rd_a_sel_in, pr_q[i]) || ovl(rd_b_sel_in, pr_q[i])));
            busy_out   = busy_out || pv_q[i];
        end
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        dp_d = dp_q;
        cc_d = cc_q;
        x_d  = x_q;
        y_d  = y_q;
        u_d  = u_q;
        s_d  = s_q;
        pc_d = pc_inc_in ? pc_q + 16'd1 : pc_q;
`ifdef REGBANK_6309_EN
        e_d  = e_q;
        f_d  = f_q;
        v_d  = v_q;
`endif
        for (int i = 0; i < 3; i++) begin
            if (i == 2 && w_en[i] && pwe_q[L]) cc_d = pcc_q[L];
            if (w_en[i]) begin
                case (w_reg[i])
                    4'h0: begin
                        a_d = w_dat[i][15:8];
                        b_d = w_dat[i][7:0];
                    end
                    4'h1: x_d  = w_dat[i];
                    4'h2: y_d  = w_dat[i];
                    4'h3: u_d  = w_dat[i];
                    4'h4: s_d  = w_dat[i];
                    4'h5: pc_d = w_dat[i];
                    4'h8: a_d  = w_dat[i][7:0];
                    4'h9: b_d  = w_dat[i][7:0];
                    4'hA: cc_d = w_dat[i][7:0];
                    4'hB: dp_d = w_dat[i][7:0];
`ifdef REGBANK_6309_EN
                    4'h6: begin
                        e_d = w_dat[i][15:8];
                        f_d = w_dat[i][7:0];
                    end
                    4'h7: v_d  = w_dat[i];
                    4'hE: e_d  = w_dat[i][7:0];
                    4'hF: f_d  = w_dat[i][7:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < WB_LAT; i++) pv_q[i] <= 1'b0;
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            dp_q <= 8'h00;
            cc_q <= 8'h50;
            x_q  <= 16'h0000;
            y_q  <= 16'h0000;
            u_q  <= 16'h0000;
            s_q  <= 16'h0000;
            pc_q <= 16'h0000;
`ifdef REGBANK_6309_EN
            e_q  <= 8'h00;
            f_q  <= 8'h00;
`endif
        end else begin
            pv_q[0] <= wb_valid_in;
            for (int i = 1; i < WB_LAT; i++) pv_q[i] <= pv_q[i-1];
            a_q  <= a_d;
            b_q  <= b_d;
            dp_q <= dp_d;
            cc_q <= cc_d;
            x_q  <= x_d;
            y_q  <= y_d;
            u_q  <= u_d;
            s_q  <= s_d;
            pc_q <= pc_d;
`ifdef REGBANK_6309_EN
            e_q  <= e_d;
            f_q  <= f_d;
`endif
        end
    end

`ifdef REGBANK_6309_EN
    // V deliberately survives reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) v_q <= v_d;
    end
`endif

    // Payload needs no reset; only the valid bits gate its use.
    always_ff @(posedge clk_in) begin
        pr_q[0]  <= wb_reg_in;
        pd_q[0]  <= wb_data_in;
        pwe_q[0] <= wb_ccr_we_in;
        pcc_q[0] <= wb_ccr_in;
        for (int i = 1; i < WB_LAT; i++) begin
            pr_q[i]  <= pr_q[i-1];
            pd_q[i]  <= pd_q[i-1];
            pwe_q[i] <= pwe_q[i-1];
            pcc_q[i] <= pcc_q[i-1];
        end
    end
endmodule
